// File: rtl/tape_ctrl.sv
// tape_ctrl: owns the tape pointer and turns single-beat tape commands into
// read, write and read-modify-write accesses on the data memory.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for a command; cmdReady high
//  RD    | ReadMem high, memDataOut sampled at the edge leaving RD
//  WR    | WriteMem high at the pointer cell, commits at the edge leaving WR
//  SWEEP | WriteMem high, zero written at sweepCnt, one cell per cycle
//  RESP  | respValid high for one cycle, then back to IDLE
module tape_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmdValid,
    output logic          cmdReady,
    input  logic [2:0]    cmdOp,
    input  logic [7:0]    cmdData,
    output logic          respValid,
    output logic [7:0]    respData,
    output logic          respZero,
    output logic [AW-1:0] ptr,
    output logic [7:0]    memAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [7:0]    memDataIn,
    input  logic [7:0]    memDataOut
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_DEC   = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_LEFT  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [2:0] {IDLE, RD, WR, SWEEP, RESP} stateT;

    stateT         state;
    stateT         nextState;
    logic [2:0]    op;
    logic [7:0]    wdata;
    logic [AW-1:0] sweepCnt;
    logic          sweepLast;
    logic          isIncDec;
    logic [7:0]    incDec;

    assign sweepLast = &sweepCnt;
    assign isIncDec  = (op == OP_INC) || (op == OP_DEC);
    assign incDec    = (op == OP_INC) ? memDataOut + 8'd1 : memDataOut - 8'd1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic and memory-side outputs, all decoded from registered state.
    always_comb begin
        nextState  = state;
        cmdReady   = 1'b0;
        respValid  = 1'b0;
        ReadMem    = 1'b0;
        WriteMem   = 1'b0;
        memDataIn  = 8'd0;
        memAddress = 8'(ptr);
        case (state)
            IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    case (cmdOp)
                        OP_NOP:   nextState = RESP;
                        OP_STORE: nextState = WR;
                        OP_CLEAR: nextState = SWEEP;
                        default:  nextState = RD;
                    endcase
                end
            end
            RD: begin
                ReadMem   = 1'b1;
                nextState = isIncDec ? WR : RESP;
            end
            WR: begin
                WriteMem  = 1'b1;
                memDataIn = wdata;
                nextState = RESP;
            end
            SWEEP: begin
                WriteMem   = 1'b1;
                memAddress = 8'(sweepCnt);
                if (sweepLast) nextState = RESP;
            end
            RESP: begin
                respValid = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: command capture, pointer, sweep counter and the response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op       <= OP_NOP;
            wdata    <= 8'd0;
            sweepCnt <= '0;
            ptr      <= '0;
            respData <= 8'd0;
            respZero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        op       <= cmdOp;
                        wdata    <= cmdData;
                        sweepCnt <= '0;
                        if (cmdOp == OP_RIGHT) ptr <= ptr + AW'(1);
                        if (cmdOp == OP_LEFT)  ptr <= ptr - AW'(1);
                    end
                end
                RD: begin
                    if (isIncDec) begin
                        wdata <= incDec;
                    end else begin
                        respData <= memDataOut;
                        respZero <= (memDataOut == 8'd0);
                    end
                end
                WR: begin
                    respData <= wdata;
                    respZero <= (wdata == 8'd0);
                end
                SWEEP: begin
                    sweepCnt <= sweepCnt + AW'(1);
                    if (sweepLast) begin
                        ptr      <= '0;
                        respData <= 8'd0;
                        respZero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_ctrl.sv
// tb_tape_ctrl: drives tape commands (directed plus random) into tape_ctrl over a
// behavioural data memory and compares against a tape/pointer reference model.
module tb_tape_ctrl;

    localparam int AW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmdValid;
    logic          cmdReady;
    logic [2:0]    cmdOp;
    logic [7:0]    cmdData;
    logic          respValid;
    logic [7:0]    respData;
    logic          respZero;
    logic [AW-1:0] ptr;
    logic [7:0]    memAddress;
    logic          ReadMem;
    logic          WriteMem;
    logic [7:0]    memDataIn;
    logic [7:0]    memDataOut;

    logic [7:0] memArr  [N];
    logic [7:0] refTape [N];
    int         refPtr;
    logic [7:0] refResp;
    logic       refZero;

    int checks = 0;
    int errors = 0;

    tape_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdOp      (cmdOp),
        .cmdData    (cmdData),
        .respValid  (respValid),
        .respData   (respData),
        .respZero   (respZero),
        .ptr        (ptr),
        .memAddress (memAddress),
        .ReadMem    (ReadMem),
        .WriteMem   (WriteMem),
        .memDataIn  (memDataIn),
        .memDataOut (memDataOut)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read while enabled, floating otherwise.
    assign memDataOut = ReadMem ? memArr[memAddress] : 8'hzz;

    always @(posedge clk) begin
        if (WriteMem) memArr[memAddress] <= memDataIn;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkTape(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) if (memArr[i] !== refTape[i]) bad++;
        checkVal(tag, bad, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, ".cmdReady"},   cmdReady,   1);
        checkVal({tag, ".respValid"},  respValid,  0);
        checkVal({tag, ".respData"},   respData,   0);
        checkVal({tag, ".respZero"},   respZero,   1);
        checkVal({tag, ".ptr"},        ptr,        0);
        checkVal({tag, ".memAddress"}, memAddress, 0);
        checkVal({tag, ".ReadMem"},    ReadMem,    0);
        checkVal({tag, ".WriteMem"},   WriteMem,   0);
        checkVal({tag, ".memDataIn"},  memDataIn,  0);
    endtask

    // Issue one command, holding cmdValid with random cmdOp noise while busy, and
    // check latency, memory traffic and the response against the reference model.
    task automatic doCmd(input logic [2:0] op, input logic [7:0] d);
        int expLat, expRd, expWr, lat, nRd, nWr, busErr, waitCyc;
        bit done;
        logic [7:0] expWData;
        expRd = 0;
        expWr = 0;
        case (op)
            3'd0: expLat = 2 - 1;
            3'd1: begin refTape[refPtr] = refTape[refPtr] + 8'd1; refResp = refTape[refPtr];
                        expLat = 3; expRd = 1; expWr = 1; end
            3'd2: begin refTape[refPtr] = refTape[refPtr] - 8'd1; refResp = refTape[refPtr];
                        expLat = 3; expRd = 1; expWr = 1; end
            3'd3: begin refPtr = (refPtr + 1) % N; refResp = refTape[refPtr]; expLat = 2; expRd = 1; end
            3'd4: begin refPtr = (refPtr + N - 1) % N; refResp = refTape[refPtr]; expLat = 2; expRd = 1; end
            3'd5: begin refResp = refTape[refPtr]; expLat = 2; expRd = 1; end
            3'd6: begin refTape[refPtr] = d; refResp = d; expLat = 2; expWr = 1; end
            default: begin
                for (int i = 0; i < N; i++) refTape[i] = 8'd0;
                refPtr = 0; refResp = 8'd0; expLat = N + 1; expWr = N;
            end
        endcase
        if (op != 3'd0) refZero = (refResp == 8'd0);
        expWData = (op == 3'd7) ? 8'd0 : refTape[refPtr];

        waitCyc = 0;
        @(negedge clk);
        while (!cmdReady && waitCyc < 20) begin @(negedge clk); waitCyc++; end
        checkVal("readyBeforeCmd", cmdReady, 1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = d;

        lat = 0; nRd = 0; nWr = 0; busErr = 0; done = 0;
        while (!done && lat < N + 20) begin
            @(posedge clk);
            #1;
            lat++;
            cmdOp   = 3'($urandom);
            cmdData = 8'($urandom);
            if (ReadMem && WriteMem) busErr++;
            if (ReadMem) begin
                if (memAddress !== 8'(refPtr)) busErr++;
                nRd++;
            end
            if (WriteMem) begin
                if (op == 3'd7) begin
                    if (memAddress !== 8'(nWr)) busErr++;
                end else if (memAddress !== 8'(refPtr)) busErr++;
                if (memDataIn !== expWData) busErr++;
                nWr++;
            end
            if (respValid) done = 1;
        end
        cmdValid = 1'b0;

        checkVal("respDone", done, 1);
        checkVal("latency", lat, expLat);
        checkVal("reads", nRd, expRd);
        checkVal("writes", nWr, expWr);
        checkVal("busErr", busErr, 0);
        checkVal("respData", respData, refResp);
        checkVal("respZero", respZero, refZero);
        checkVal("ptr", ptr, refPtr);

        @(posedge clk);
        #1;
        checkVal("respOneCycle", respValid, 0);
        checkVal("readyAfter", cmdReady, 1);
        checkVal("respHeld", respData, refResp);
        checkVal("cell", memArr[refPtr], refTape[refPtr]);
    endtask

    // Abort an INC on a cell holding 0x05 with reset during its RD cycle.
    task automatic resetDuringInc();
        int bad;
        int p;
        p = refPtr;
        @(negedge clk);
        cmdValid = 1'b1;
        cmdOp    = 3'd1;
        cmdData  = 8'h00;
        @(posedge clk);
        #1;
        checkVal("abortInRd", ReadMem, 1);
        reset = 1'b1;
        #1;
        cmdValid = 1'b0;
        checkResetOutputs("midReset");
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (WriteMem || respValid) bad++;
        end
        checkVal("abortQuiet", bad, 0);
        @(negedge clk);
        reset = 1'b0;
        checkVal("abortCell", memArr[p], 8'h05);
        refPtr  = 0;
        refResp = 8'd0;
        refZero = 1'b1;
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] rdat;
        reset    = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = 3'd0;
        cmdData  = 8'd0;
        for (int i = 0; i < N; i++) begin
            memArr[i]  = 8'($urandom);
            refTape[i] = memArr[i];
        end
        refPtr  = 0;
        refResp = 8'd0;
        refZero = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // STORE then LOAD at cell 0.
        doCmd(3'd6, 8'h41);
        doCmd(3'd5, 8'h00);
        // INC wrap to zero, DEC wrap back.
        doCmd(3'd6, 8'hFF);
        doCmd(3'd1, 8'h00);
        doCmd(3'd2, 8'h00);
        // Pointer wrap both ways.
        doCmd(3'd4, 8'h00);
        doCmd(3'd3, 8'h00);
        doCmd(3'd0, 8'h00);

        // Seed 0x00, 0xFF and 0x10, leave ptr at 0x10, then clear the tape.
        doCmd(3'd6, 8'h11);
        doCmd(3'd4, 8'h00);
        doCmd(3'd6, 8'h22);
        doCmd(3'd3, 8'h00);
        repeat (16) doCmd(3'd3, 8'h00);
        doCmd(3'd6, 8'h33);
        doCmd(3'd7, 8'h00);
        checkTape("tapeCleared");
        repeat (16) doCmd(3'd3, 8'h00);
        doCmd(3'd5, 8'h00);
        doCmd(3'd4, 8'h00);
        repeat (16) doCmd(3'd4, 8'h00);
        doCmd(3'd5, 8'h00);

        // Reset in the RD cycle of an INC on a cell holding 0x05.
        repeat (3) doCmd(3'd3, 8'h00);
        doCmd(3'd6, 8'h05);
        resetDuringInc();
        checkTape("tapeAfterAbort");

        // Random command stream.
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 99) < 2) rop = 3'd7;
            else                           rop = 3'($urandom_range(0, 6));
            case ($urandom_range(0, 3))
                0:       rdat = 8'h00;
                1:       rdat = 8'hFF;
                default: rdat = 8'($urandom);
            endcase
            doCmd(rop, rdat);
        end
        checkTape("tapeFinal");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tape_ctrl.md
# tape_ctrl

Initiator side of the data-memory port: owns the tape pointer and turns single-beat tape commands into read, write and read-modify-write accesses on the data memory. Sits between the instruction decoder and the data memory. Supported commands are cell increment/decrement, pointer move, load, store and whole-tape clear. Results return on a one-cycle response strobe with a zero flag for loop branching.

## Interface
- AW, 8, memory address width; tape length is 2**AW cells.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cmdValid  in  1  command offered.
- cmdReady  out  1  controller can accept; high only in IDLE.
- cmdOp  in  3  0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 LOAD, 6 STORE, 7 CLEAR_ALL.
- cmdData  in  8 (BYTE)  store value; used only by STORE.
- respValid  out  1  one-cycle result strobe.
- respData  out  8 (BYTE)  resulting cell value; held until next strobe.
- respZero  out  1  respData == 0; registered with respData.
- ptr  out  AW  current tape pointer.
- memAddress  out  8 (BYTE)  memory address; ptr zero-extended, or sweep counter in SWEEP.
- ReadMem  out  1  memory read enable.
- WriteMem  out  1  memory write enable.
- memDataIn  out  8 (BYTE)  write data to memory.
- memDataOut  in  8 (BYTE)  combinational read data; valid only while ReadMem=1, high-Z otherwise.

## Operation
- States: IDLE, RD, WR, SWEEP, RESP.
- Accept when cmdValid && cmdReady at a posedge. Capture cmdOp/cmdData; cmdOp ignored at all other times.
- INC/DEC: IDLE→RD→WR→RESP.
  - RD: ReadMem=1; wdata <= memDataOut ±1 mod 256 (255+1=0, 0−1=255).
  - WR: WriteMem=1, memDataIn=wdata.
  - RESP: respData=wdata.
- RIGHT/LEFT: ptr ±1 mod 2**AW at the accept edge. Then IDLE→RD→RESP; respData is the new cell value.
- LOAD: IDLE→RD→RESP; respData=memDataOut sampled in RD.
- STORE: IDLE→WR→RESP; memDataIn=cmdData; respData=cmdData.
- NOP: IDLE→RESP; respData/respZero unchanged.
- CLEAR_ALL: IDLE→SWEEP.
  - Counter runs 0..2**AW−1, one address per cycle, with WriteMem=1, memDataIn=0, memAddress=counter.
  - After the last address: ptr<=0, then →RESP with respData=0, respZero=1.
- RESP always →IDLE at the next edge.
- ReadMem=1 only in RD; WriteMem=1 only in WR and SWEEP. Both are 0 in IDLE and RESP.
- memDataOut is sampled only in RD and never used while ReadMem=0, so no X/Z propagates.
- respData/respZero are updated only on entry to RESP and are otherwise stable.

## Timing
- Latency from accept edge E0 to respValid (high during the cycle after edge En):
  - NOP: n=1.
  - LOAD/STORE/RIGHT/LEFT: n=2.
  - INC/DEC: n=3.
  - CLEAR_ALL: n=2**AW+1.
- Throughput: cmdReady rises one cycle after RESP. Minimum command spacing is 3 cycles for LOAD-class commands.
- memAddress, ReadMem, WriteMem and memDataIn are glitch-free functions of registered state; a write commits at the edge that leaves WR/SWEEP.
- Reset values: state IDLE, cmdReady=1, respValid=0, respData=0, respZero=1, ptr=0, memAddress=0, ReadMem=0, WriteMem=0, memDataIn=0, sweep counter=0.
- Reset mid-operation: aborts immediately with no respValid.
  - An INC/DEC aborted in RD leaves the cell unchanged.
  - Cells already cleared by a partial SWEEP stay cleared.
- Holding cmdValid high with a new cmdOp while cmdReady=0 has no effect.
- Pointer wrap: RIGHT at 2**AW−1 → 0; LEFT at 0 → 2**AW−1.

## Test plan
- Reset, then STORE cmdData=0x41 at ptr 0 → WriteMem pulse at address 0 two edges after accept; respData=0x41, respZero=0; subsequent LOAD returns 0x41.
- Cell 0 = 0xFF, INC → RD, WR (memDataIn=0x00), respValid three edges after accept, respData=0x00, respZero=1. Then DEC → respData=0xFF.
- From ptr=0, LEFT → ptr=0xFF, memAddress=0xFF during RD. Then RIGHT → ptr=0x00, and respData equals the cell-0 contents.
- Seed cells 0x00, 0x10 and 0xFF nonzero with ptr=0x10, then CLEAR_ALL:
  - exactly 256 consecutive WriteMem cycles on addresses 0..255;
  - respValid at edge 257, respZero=1, ptr=0;
  - LOAD at 0x10 and 0xFF returns 0.
- Assert reset during the RD cycle of an INC on a cell holding 0x05 → no WriteMem, no respValid, cell still 0x05, all outputs at reset values.
- Hold cmdValid=1 with changing cmdOp during a busy INC → only the originally accepted op executes; the next accept occurs only after cmdReady returns.
